// File: rtl/pac_dir_ctrl.sv
// Pac-Man direction controller: synchronizes and debounces the four
// board buttons and turns presses into a held one-hot movement direction.
module pac_dir_ctrl #(
  parameter int unsigned DB_MAX = 500000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic freeze,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic moving,
  output logic dir_chg
);

  typedef enum logic [2:0] {
    D_NONE,
    D_UP,
    D_DOWN,
    D_LEFT,
    D_RIGHT
  } dir_e;

  typedef enum logic {
    S_IDLE,
    S_MOVE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // bit 3 = up, 2 = down, 1 = left, 0 = right
  logic [3:0] btn;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] stab_q;
  logic [3:0] prev_q;
  logic [3:0] press_q;
  logic [CNT_W-1:0] cnt_q [4];

  assign btn = {btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      press_q <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      prev_q  <= stab_q;
      press_q <= stab_q & ~prev_q;
    end
  end

  // A single agreeing cycle restarts the count; the counter never passes CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == stab_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stab_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  dir_e   win;
  dir_e   held_q, held_d;
  state_e state_q, state_d;
  logic   chg_d;
  logic [3:0] oh_d;
  logic [3:0] oh_q;
  logic   moving_q;
  logic   chg_q;

  always_comb begin
    win = D_NONE;
    if (press_q[3])      win = D_UP;
    else if (press_q[2]) win = D_DOWN;
    else if (press_q[1]) win = D_LEFT;
    else if (press_q[0]) win = D_RIGHT;
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    chg_d   = 1'b0;
    if (!freeze && win != D_NONE) begin
      if (state_q == S_IDLE || win != held_q) begin
        state_d = S_MOVE;
        held_d  = win;
        chg_d   = 1'b1;
      end
    end
  end

  always_comb begin
    oh_d = 4'b0000;
    unique case (held_d)
      D_UP:    oh_d = 4'b1000;
      D_DOWN:  oh_d = 4'b0100;
      D_LEFT:  oh_d = 4'b0010;
      D_RIGHT: oh_d = 4'b0001;
      default: oh_d = 4'b0000;
    endcase
    if (freeze) oh_d = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      held_q   <= D_NONE;
      oh_q     <= '0;
      moving_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      oh_q     <= oh_d;
      moving_q <= (state_d == S_MOVE) && !freeze;
      chg_q    <= chg_d;
    end
  end

  assign up      = oh_q[3];
  assign down    = oh_q[2];
  assign left    = oh_q[1];
  assign right   = oh_q[0];
  assign moving  = moving_q;
  assign dir_chg = chg_q;

endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Bench for pac_dir_ctrl: table of timed button records plus
// hand sequences for bounce and asynchronous reset.
module tb_pac_dir_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic freeze = 1'b0;
  logic up, down, left, right, moving, dir_chg;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       frz;
    int         cyc;
    logic [4:0] exp;
    int         chg;
  } vec_t;

  vec_t tbl[$];
  logic [4:0] exp_q[$];

  pac_dir_ctrl #(
    .DB_MAX(4),
    .CNT_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .freeze   (freeze),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .moving   (moving),
    .dir_chg  (dir_chg)
  );

  always #5 clk = ~clk;

  assign outs = {up, down, left, right, moving};

  function automatic vec_t mk(logic r, logic [3:0] b, logic f,
                              int c, logic [4:0] e, int g);
    vec_t v;
    v.rst = r;
    v.btn = b;
    v.frz = f;
    v.cyc = c;
    v.exp = e;
    v.chg = g;
    return v;
  endfunction

  // Expected outputs are queued at drive time and popped after the last cycle.
  task automatic run(input vec_t v, input string name);
    int n;
    logic [4:0] e;
    n = 0;
    exp_q.push_back(v.exp);
    for (int c = 0; c < v.cyc; c++) begin
      rst = v.rst;
      {btn_up, btn_down, btn_left, btn_right} = v.btn;
      freeze = v.frz;
      @(posedge clk);
      #1;
      if (dir_chg) n++;
      checks++;
      if ($countones(outs[4:1]) != 32'(moving)) begin
        errors++;
        $display("FAIL %s onehot: dirs=%b moving=%b", name, outs[4:1], moving);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL %s outs(udlrm): got %b want %b", name, outs, e);
    end
    checks++;
    if (n != v.chg) begin
      errors++;
      $display("FAIL %s dir_chg pulses: got %0d want %0d", name, n, v.chg);
    end
  endtask

  initial begin
    // reset and clean right press
    tbl.push_back(mk(1, 4'b0000, 0, 2, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 7, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 5'b00011, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 5'b00011, 0));
    // right held, press left, release all
    tbl.push_back(mk(0, 4'b0011, 0, 7, 5'b00011, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 1, 5'b00101, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 10, 5'b00101, 0));
    // simultaneous up+left from idle, then repeat up
    tbl.push_back(mk(1, 4'b0000, 0, 2, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 7, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 1, 5'b10001, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 5'b10001, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 10, 5'b10001, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 5'b10001, 0));
    // reversal to down, then freeze with left press
    tbl.push_back(mk(0, 4'b0100, 0, 7, 5'b10001, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 1, 5'b01001, 1));
    tbl.push_back(mk(0, 4'b0100, 1, 1, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 10, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 1, 5'b01001, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 5'b01001, 0));
    // press while frozen in idle is lost
    tbl.push_back(mk(1, 4'b0000, 0, 2, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 12, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 3, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 5'b00000, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 8, 5'b00011, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 8, 5'b00011, 0));

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // bounce on up, then steady
    run(mk(1, 4'b0000, 0, 2, 5'b00000, 0), "bnc_rst");
    for (int k = 0; k < 2; k++) begin
      run(mk(0, 4'b1000, 0, 2, 5'b00000, 0), "bnc_hi");
      run(mk(0, 4'b0000, 0, 2, 5'b00000, 0), "bnc_lo");
    end
    run(mk(0, 4'b1000, 0, 7, 5'b00000, 0), "bnc_wait");
    run(mk(0, 4'b1000, 0, 1, 5'b10001, 1), "bnc_up");
    run(mk(0, 4'b1000, 0, 10, 5'b10001, 0), "bnc_hold");

    // async reset mid-move and mid-debounce of right
    run(mk(0, 4'b0001, 0, 3, 5'b10001, 0), "ar_pre");
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 5'b00000 || dir_chg !== 1'b0) begin
      errors++;
      $display("FAIL async_rst outs: got %b chg %b want 00000 0", outs, dir_chg);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(mk(0, 4'b0001, 0, 7, 5'b00000, 0), "ar_wait");
    run(mk(0, 4'b0001, 0, 1, 5'b00011, 1), "ar_right");
    run(mk(0, 4'b0001, 0, 1, 5'b00011, 0), "ar_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
